pfft_serializer: RTL and testbench

Downstream stage of `pfft`. Accepts one parallel FFT result beat of 2^FFT_ORDER complex samples per valid cycle and buffers whole beats in a small FIFO. It emits them as a serial AXI-Stream of one complex sample per cycle with backpressure, in natural or bit-reversed lane order, tagged with bin index and frame end. `pfft` has no ready input, so this block absorbs the rate mismatch and flags overflow.

---
 rtl/pfft_pkg.sv | 30 +++
 rtl/pfft_beat_fifo.sv | 51 +++++
 rtl/pfft_serializer.sv | 124 ++++++++++++
 tb/tb_pfft_serializer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pfft_pkg.sv
// Shared types and helpers for the pfft datapath and its serializer.
package pfft_pkg;

  localparam int PFFT_CW = 32;

  // One complex sample as produced by pfft: {imag, real}.
  typedef struct packed {
    logic [PFFT_CW/2-1:0] im;
    logic [PFFT_CW/2-1:0] re;
  } pfft_cplx_t;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

  function automatic int lane_count(input int order);
    return 1 << order;
  endfunction

  function automatic int bitrev(input int k, input int order);
    int r;
    r = 0;
    for (int i = 0; i < order; i++) begin
      if (((k >> i) & 1) != 0) r = r | (1 << (order - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/pfft_beat_fifo.sv
// Whole-beat FIFO with combinational head read from flop storage.
module pfft_beat_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;

  // Storage is not reset; validity is tracked by level_reg alone.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;

endmodule

// File: rtl/pfft_serializer.sv
// Buffers parallel pfft beats and streams them out one complex sample per cycle.
module pfft_serializer
  import pfft_pkg::*;
#(
  parameter int FFT_ORDER      = 2,
  parameter int COMPLEX_DWIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int BIT_REVERSE    = 0
) (
  input  logic                                          aclk,
  input  logic                                          areset,
  input  logic                                          s_axis_tvalid,
  input  logic [(1<<FFT_ORDER)*COMPLEX_DWIDTH-1:0]      s_axis_tdata,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic [COMPLEX_DWIDTH-1:0]                     m_axis_tdata,
  output logic                                          m_axis_tlast,
  output logic [FFT_ORDER-1:0]                          m_axis_tuser,
  output logic                                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]                   fifo_level
);

  localparam int N  = lane_count(FFT_ORDER);
  localparam int CW = COMPLEX_DWIDTH;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FFT_ORDER-1:0] K_LAST = {FFT_ORDER{1'b1}};

  logic [N*CW-1:0]      fifo_rd_data;
  logic                 fifo_full, fifo_empty;
  logic [LW-1:0]        fifo_level_w;
  logic                 push, pop, load, avail;
  logic [CW-1:0]        lane_perm [N];

  rd_state_e            state_reg, state_next;
  logic [FFT_ORDER-1:0] k_reg, k_next;
  logic                 tvalid_reg, tvalid_next;
  logic [CW-1:0]        tdata_reg, tdata_next;
  logic [FFT_ORDER-1:0] tuser_reg, tuser_next;
  logic                 tlast_reg, tlast_next;
  logic                 overflow_reg, overflow_next;

  pfft_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (N*CW)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .push    (push),
    .wr_data (s_axis_tdata),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_w)
  );

  // Lane order is fixed at elaboration, so the permutation is pure wiring.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam int SRC = (BIT_REVERSE != 0) ? bitrev(gi, FFT_ORDER) : gi;
    assign lane_perm[gi] = fifo_rd_data[SRC*CW +: CW];
  end

  assign load  = !tvalid_reg || m_axis_tready;
  assign avail = !fifo_empty;
  assign pop   = load && avail && (k_reg == K_LAST);
  // A full FIFO still accepts a beat if the head retires on the same edge.
  assign push  = s_axis_tvalid && (!fifo_full || pop);

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    tvalid_next   = tvalid_reg;
    tdata_next    = tdata_reg;
    tuser_next    = tuser_reg;
    tlast_next    = tlast_reg;
    overflow_next = overflow_reg | (s_axis_tvalid && !push);

    if (load) begin
      if (avail) begin
        tvalid_next = 1'b1;
        tdata_next  = lane_perm[k_reg];
        tuser_next  = k_reg;
        tlast_next  = (k_reg == K_LAST);
        k_next      = k_reg + 1'b1;
      end else begin
        tvalid_next = 1'b0;
      end
    end

    case (state_reg)
      RD_IDLE:   if (avail) state_next = RD_STREAM;
      RD_STREAM: if (!avail || (pop && !push && fifo_level_w == LW'(1))) state_next = RD_IDLE;
      default:   state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= RD_IDLE;
      k_reg        <= '0;
      tvalid_reg   <= 1'b0;
      tdata_reg    <= '0;
      tuser_reg    <= '0;
      tlast_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      tvalid_reg   <= tvalid_next;
      tdata_reg    <= tdata_next;
      tuser_reg    <= tuser_next;
      tlast_reg    <= tlast_next;
      overflow_reg <= overflow_next;
    end
  end

  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tuser  = tuser_reg;
  assign m_axis_tlast  = tlast_reg;
  assign overflow      = overflow_reg;
  assign fifo_level    = fifo_level_w;

endmodule

// File: tb/tb_pfft_serializer.sv
// Directed bench for pfft_serializer: natural and bit-reversed instances share stimulus.
module tb_pfft_serializer;

  localparam int N  = 4;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_tvalid = 1'b0;
  logic [N*CW-1:0] s_tdata = '0;
  logic          tready = 1'b0;

  logic          nat_tvalid, rev_tvalid;
  logic [CW-1:0] nat_tdata, rev_tdata;
  logic          nat_tlast, rev_tlast;
  logic [1:0]    nat_tuser, rev_tuser;
  logic          nat_ovf, rev_ovf;
  logic [2:0]    nat_level, rev_level;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  pfft_serializer #(.FFT_ORDER(2), .COMPLEX_DWIDTH(CW), .FIFO_DEPTH(4), .BIT_REVERSE(0)) dut_nat (
    .aclk(aclk), .areset(areset), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(nat_tvalid), .m_axis_tready(tready), .m_axis_tdata(nat_tdata),
    .m_axis_tlast(nat_tlast), .m_axis_tuser(nat_tuser), .overflow(nat_ovf), .fifo_level(nat_level)
  );

  pfft_serializer #(.FFT_ORDER(2), .COMPLEX_DWIDTH(CW), .FIFO_DEPTH(4), .BIT_REVERSE(1)) dut_rev (
    .aclk(aclk), .areset(areset), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(rev_tvalid), .m_axis_tready(tready), .m_axis_tdata(rev_tdata),
    .m_axis_tlast(rev_tlast), .m_axis_tuser(rev_tuser), .overflow(rev_ovf), .fifo_level(rev_level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Beat 0 gives lanes 0x00000000, 0x11111111, 0x22222222, 0x33333333.
  function automatic logic [CW-1:0] lane_val(input int b, input int i);
    return (32'h11111111 * 32'(i)) ^ (32'(b) << 28);
  endfunction

  function automatic logic [N*CW-1:0] mk_beat(input int b);
    logic [N*CW-1:0] v;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = lane_val(b, i);
    return v;
  endfunction

  task automatic push_beat(input int b);
    s_tvalid = 1'b1;
    s_tdata  = mk_beat(b);
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Collect `count` samples from the natural instance with tready held high.
  task automatic drain_check(input string tag, input int first_b, input int first_i, input int count);
    int got = 0;
    int cyc = 0;
    int b = first_b;
    int i = first_i;
    tready = 1'b1;
    while (got < count && cyc < 200) begin
      if (nat_tvalid) begin
        $display("%s sample %0d: tuser=%0d tdata=%08h tlast=%0d", tag, got, nat_tuser, nat_tdata, nat_tlast);
        check({tag, "_data"}, 64'(nat_tdata), 64'(lane_val(b, i)));
        check({tag, "_user"}, 64'(nat_tuser), 64'(i));
        check({tag, "_last"}, 64'(nat_tlast), 64'(i == N-1));
        got++;
        i++;
        if (i == N) begin
          i = 0;
          b++;
        end
      end
      tick();
      cyc++;
    end
    check({tag, "_count"}, 64'(got), 64'(count));
  endtask

  initial begin
    int rv [4] = '{0, 2, 1, 3};
    int got;
    logic stalled;
    logic [CW-1:0] prev_data;
    logic [1:0] prev_user;

    do_reset();
    check("rst_tvalid", 64'(nat_tvalid), 64'(0));
    check("rst_tdata",  64'(nat_tdata),  64'(0));
    check("rst_tuser",  64'(nat_tuser),  64'(0));
    check("rst_tlast",  64'(nat_tlast),  64'(0));
    check("rst_ovf",    64'(nat_ovf),    64'(0));
    check("rst_level",  64'(nat_level),  64'(0));

    // Natural and bit-reversed order, first sample valid after edge e+1.
    tready = 1'b1;
    push_beat(0);
    check("lat_level",  64'(nat_level),  64'(1));
    check("lat_tvalid", 64'(nat_tvalid), 64'(0));
    tick();
    for (int j = 0; j < N; j++) begin
      $display("order sample %0d: nat=%08h rev=%08h tuser=%0d", j, nat_tdata, rev_tdata, nat_tuser);
      check("nat_tvalid", 64'(nat_tvalid), 64'(1));
      check("nat_tdata",  64'(nat_tdata),  64'(lane_val(0, j)));
      check("nat_tuser",  64'(nat_tuser),  64'(j));
      check("nat_tlast",  64'(nat_tlast),  64'(j == N-1));
      check("rev_tdata",  64'(rev_tdata),  64'(lane_val(0, rv[j])));
      check("rev_tuser",  64'(rev_tuser),  64'(j));
      tick();
    end
    check("order_end_tvalid", 64'(nat_tvalid), 64'(0));
    check("order_end_level",  64'(nat_level),  64'(0));

    // Backpressure: tready pattern 1,0,0,1 repeating.
    tready = 1'b0;
    push_beat(2);
    got = 0;
    stalled = 1'b0;
    prev_data = '0;
    prev_user = '0;
    for (int c = 0; c < 24; c++) begin
      tready = ((c % 4) == 0) || ((c % 4) == 3);
      if (stalled) begin
        check("bp_hold_data", 64'(nat_tdata), 64'(prev_data));
        check("bp_hold_user", 64'(nat_tuser), 64'(prev_user));
      end
      if (nat_tvalid && tready) begin
        $display("bp sample %0d: tuser=%0d tdata=%08h", got, nat_tuser, nat_tdata);
        check("bp_data", 64'(nat_tdata), 64'(lane_val(2, got)));
        check("bp_user", 64'(nat_tuser), 64'(got));
        got++;
      end
      stalled   = nat_tvalid && !tready;
      prev_data = nat_tdata;
      prev_user = nat_tuser;
      tick();
    end
    check("bp_count", 64'(got), 64'(4));

    // Overflow: six beats into a depth-4 FIFO with the sink stalled.
    tready = 1'b0;
    for (int b = 1; b <= 6; b++) push_beat(b);
    check("ovf_level",  64'(nat_level),  64'(4));
    check("ovf_flag",   64'(nat_ovf),    64'(1));
    check("ovf_tvalid", 64'(nat_tvalid), 64'(1));
    check("ovf_head",   64'(nat_tdata),  64'(lane_val(1, 0)));
    drain_check("ovf", 1, 0, 16);
    check("ovf_sticky",    64'(nat_ovf),    64'(1));
    check("ovf_end_valid", 64'(nat_tvalid), 64'(0));
    check("ovf_end_level", 64'(nat_level),  64'(0));

    // Full FIFO plus head retiring on the edge a new beat arrives.
    do_reset();
    tready = 1'b0;
    for (int b = 11; b <= 14; b++) push_beat(b);
    tready = 1'b1;
    tick();
    tick();
    push_beat(15);
    check("fr_level", 64'(nat_level), 64'(4));
    check("fr_ovf",   64'(nat_ovf),   64'(0));
    check("fr_tdata", 64'(nat_tdata), 64'(lane_val(11, 3)));
    check("fr_tlast", 64'(nat_tlast), 64'(1));
    drain_check("fr", 11, 3, 17);
    check("fr_end_ovf",   64'(nat_ovf),   64'(0));
    check("fr_end_level", 64'(nat_level), 64'(0));

    // Reset after two of four samples have been taken.
    tready = 1'b1;
    push_beat(7);
    tick();
    tick();
    tick();
    check("mid_tuser", 64'(nat_tuser), 64'(2));
    areset = 1'b1;
    tick();
    check("mid_rst_tvalid", 64'(nat_tvalid), 64'(0));
    check("mid_rst_level",  64'(nat_level),  64'(0));
    check("mid_rst_tuser",  64'(nat_tuser),  64'(0));
    areset = 1'b0;
    tick();
    check("mid_no_tail", 64'(nat_tvalid), 64'(0));
    push_beat(8);
    check("mid_new_lat", 64'(nat_tvalid), 64'(0));
    tick();
    drain_check("mid", 8, 0, 4);
    check("mid_end_tvalid", 64'(nat_tvalid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
